// File: rtl/tick_scheduler_if.sv
// Configuration port of the tick scheduler: a valid/ready request carrying
// channel, divisor and enable, plus a one-cycle error pulse for bad channels.
interface tick_scheduler_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 28
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_en;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_en,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_en,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/tick_scheduler.sv
// Runtime-programmable multi-channel tick scheduler. Each channel divides clk by
// its own divisor; new settings wait in a shadow register until the channel wraps.
module tick_scheduler #(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 28,
  parameter int DEF_DIV = 25000000,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  tick_scheduler_if.slave   cfg,
  output logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sig_out
);

  logic [CNT_W-1:0]  cnt        [NUM_CH];
  logic [CNT_W-1:0]  active_div [NUM_CH];
  logic [CNT_W-1:0]  shadow_div [NUM_CH];
  logic [NUM_CH-1:0] shadow_en;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] accept;
  logic [CNT_W-1:0]  cfg_div_fix;
  logic              ch_valid;
  logic              ready;
  logic              err_q;

  // Out-of-range channels are always ready so a bad request is consumed, never stalled.
  always_comb begin
    ch_valid    = (32'(cfg.cfg_ch) < NUM_CH);
    cfg_div_fix = (cfg.cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg.cfg_div;
    ready       = 1'b1;
    accept      = '0;
    wrap        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        if (pending[i])
          ready = 1'b0;
        else
          accept[i] = cfg.cfg_valid;
      end
      wrap[i] = ch_en[i] && (cnt[i] == active_div[i] - CNT_W'(1));
    end
  end

  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = err_q;

  // Accept and apply never coincide on one channel: accept needs pending low, apply needs it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]        <= '0;
        active_div[i] <= CNT_W'(DEF_DIV);
        shadow_div[i] <= CNT_W'(DEF_DIV);
      end
      shadow_en <= '0;
      ch_en     <= '1;
      pending   <= '0;
      tick      <= '0;
      sig_out   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= cfg.cfg_valid && !ch_valid;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i]) begin
          shadow_div[i] <= cfg_div_fix;
          shadow_en[i]  <= cfg.cfg_en;
          pending[i]    <= 1'b1;
        end
        if (ch_en[i]) begin
          if (wrap[i]) begin
            cnt[i]     <= '0;
            tick[i]    <= 1'b1;
            sig_out[i] <= ~sig_out[i];
            if (pending[i]) begin
              active_div[i] <= shadow_div[i];
              ch_en[i]      <= shadow_en[i];
              pending[i]    <= 1'b0;
            end
          end else begin
            cnt[i]  <= cnt[i] + CNT_W'(1);
            tick[i] <= 1'b0;
          end
        end else begin
          // A disabled channel has no wrap to wait for, so it applies immediately.
          cnt[i]     <= '0;
          tick[i]    <= 1'b0;
          sig_out[i] <= 1'b0;
          if (pending[i]) begin
            active_div[i] <= shadow_div[i];
            ch_en[i]      <= shadow_en[i];
            pending[i]    <= 1'b0;
          end
        end
      end
    end
  end

endmodule
